// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU_32 between two requesters.
// Each accepted operation is registered into the ALU, its result captured one
// cycle later, and returned on a single response channel tagged with the source.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  // Requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_ctrl,
  // Requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_ctrl,
  // ALU_32 interface
  output logic [WIDTH-1:0] A_in,
  output logic [WIDTH-1:0] B_in,
  output logic [3:0]       ALU_ctrl,
  input  logic [WIDTH-1:0] ALU_out,
  input  logic             zero,
  input  logic             carry_out,
  input  logic             overflow,
  // Response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_flags,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  // Requester that wins a tie in IDLE; flips to the other side after every grant.
  logic   rr_ptr;
  logic   grant0;
  logic   grant1;

  function automatic logic ctrl_legal(input logic [3:0] code);
    logic ok;
    case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0110,
      4'b0111, 4'b1100, 4'b1111: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Grant selection: a lone valid wins, a tie goes to the priority holder.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || (rr_ptr == 1'b0));
    grant1 = req1_valid && (!req0_valid || (rr_ptr == 1'b1));
  end

  assign req0_ready = !rst && (state == IDLE) && grant0;
  assign req1_ready = !rst && (state == IDLE) && grant1;

  // Arbitration / execute / response FSM with registered ALU and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      A_in      <= '0;
      B_in      <= '0;
      ALU_ctrl  <= 4'b0000;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= 3'b000;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            A_in     <= req0_a;
            B_in     <= req0_b;
            ALU_ctrl <= req0_ctrl;
            rsp_id   <= 1'b0;
            rr_ptr   <= 1'b1;
            state    <= EXEC;
          end else if (grant1) begin
            A_in     <= req1_a;
            B_in     <= req1_b;
            ALU_ctrl <= req1_ctrl;
            rsp_id   <= 1'b1;
            rr_ptr   <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (ctrl_legal(ALU_ctrl)) begin
            rsp_data  <= ALU_out;
            rsp_flags <= {overflow, carry_out, zero};
            rsp_err   <= 1'b0;
          end else begin
            // Illegal code: the ALU output is meaningless, so report clean zeros.
            rsp_data  <= '0;
            rsp_flags <= 3'b000;
            rsp_err   <= 1'b1;
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU_32 attached to its ALU port.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [31:0] A_in, B_in, ALU_out;
  logic [3:0]  ALU_ctrl;
  logic        zero, carry_out, overflow;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_flags;

  int n_checks = 0;
  int n_pass   = 0;
  int n_rsp    = 0;

  // {id, err, flags[2:0], data[31:0]}
  logic [36:0] exp_q[$];
  bit          grant_q[$];

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .A_in(A_in), .B_in(B_in), .ALU_ctrl(ALU_ctrl),
    .ALU_out(ALU_out), .zero(zero), .carry_out(carry_out), .overflow(overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  // Returns {overflow, carry_out, zero, result}; illegal codes give deliberate garbage.
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
    logic [31:0] r;
    logic        co, ov, z, bw;
    co = 1'b0;
    ov = 1'b0;
    bw = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        {co, r} = {1'b0, a} + {1'b0, b};
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0110: begin
        {bw, r} = {1'b0, a} - {1'b0, b};
        co = ~bw;
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      4'b1111: r = (a == b) ? 32'd1 : 32'd0;
      default: begin
        r  = a ^ b ^ 32'hdead_beef;
        co = 1'b1;
        ov = 1'b1;
      end
    endcase
    z = (r == 32'd0);
    return {ov, co, z, r};
  endfunction

  function automatic logic [36:0] make_exp(input bit id, input logic [31:0] a,
                                           input logic [31:0] b, input logic [3:0] c);
    logic [34:0] m;
    bit          legal;
    legal = (c == 4'b0000) || (c == 4'b0001) || (c == 4'b0010) || (c == 4'b0110) ||
            (c == 4'b0111) || (c == 4'b1100) || (c == 4'b1111);
    m = alu_model(a, b, c);
    if (legal) return {id, 1'b0, m[34:32], m[31:0]};
    return {id, 1'b1, 3'b000, 32'd0};
  endfunction

  // Behavioural ALU_32 driven by the DUT's registered operands.
  always_comb begin
    logic [34:0] m;
    m = alu_model(A_in, B_in, ALU_ctrl);
    ALU_out   = m[31:0];
    zero      = m[32];
    carry_out = m[33];
    overflow  = m[34];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Monitor: record accepted requests as expectations, compare accepted responses.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (req0_ready && req1_ready) check("dual_ready", 1, 0);
      if (req0_valid && req0_ready) begin
        exp_q.push_back(make_exp(1'b0, req0_a, req0_b, req0_ctrl));
        grant_q.push_back(1'b0);
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back(make_exp(1'b1, req1_a, req1_b, req1_ctrl));
        grant_q.push_back(1'b1);
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
        else check("rsp", {27'd0, rsp_id, rsp_err, rsp_flags, rsp_data},
                   {27'd0, exp_q.pop_front()});
      end
    end
  end

  // Holds one requester's valid until n operations are accepted (caller at posedge+1).
  task automatic drive(input bit id, input int n, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c);
    int got   = 0;
    int guard = 0;
    if (id == 1'b0) begin
      req0_a = a; req0_b = b; req0_ctrl = c; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_ctrl = c; req1_valid = 1'b1;
    end
    while (got < n && guard < 200) begin
      @(negedge clk);
      guard++;
      if ((id == 1'b0) ? req0_ready : req1_ready) begin
        got++;
        @(posedge clk); #1;
        if (got == n) begin
          if (id == 1'b0) req0_valid = 1'b0;
          else req1_valid = 1'b0;
        end
      end
    end
    if (got < n) begin
      check("drive_timeout", got, n);
      if (id == 1'b0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || rsp_valid) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int saved;
    int guard;
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_ctrl = 4'b0010;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_ctrl = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_outs", {rsp_valid, rsp_id, rsp_err, rsp_flags, ALU_ctrl}, 0);
    check("rst_data", {A_in, B_in}, 0);
    check("rst_rsp_data", rsp_data, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single ADD on req0: ready at once, response two cycles after grant.
    req0_a = 32'ha86a0c31; req0_b = 32'h90073fd4; req0_ctrl = 4'b0010; req0_valid = 1'b1;
    @(negedge clk);
    check("add_ready", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("add_exec_valid", rsp_valid, 0);
    check("add_a_in", A_in, 32'ha86a0c31);
    check("add_ctrl", ALU_ctrl, 4'b0010);
    @(negedge clk);
    check("add_rsp_valid", rsp_valid, 1);
    check("add_rsp_data", rsp_data, 32'h38714c05);
    check("add_rsp_meta", {rsp_id, rsp_err, rsp_flags}, {1'b0, 1'b0, 3'b110});
    @(posedge clk); #1;
    drain();

    // SUB on req1.
    drive(1'b1, 1, 32'ha86a0c31, 32'h90073fd4, 4'b0110);
    @(negedge clk);
    @(negedge clk);
    check("sub_rsp_data", rsp_data, 32'h1862cc5d);
    check("sub_rsp_meta", {rsp_valid, rsp_id, rsp_err, rsp_flags[0]}, 4'b1100);
    @(posedge clk); #1;
    drain();

    // Both requesters valid from reset: grants must alternate 0,1,0,1...
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clk); #1;
    check("rst2_ready", {req0_ready, req1_ready}, 0);
    rst = 1'b0;
    grant_q.delete();
    fork
      drive(1'b0, 4, 32'ha86a0c31, 32'ha86a0c31, 4'b1111);
      drive(1'b1, 4, 32'h086a0c31, 32'hd785f148, 4'b0000);
    join
    drain();
    check("fair_count", grant_q.size(), 8);
    for (int i = 0; i < 8 && i < grant_q.size(); i++)
      check($sformatf("fair_order%0d", i), grant_q[i], i % 2);

    // Response stall: outputs hold, no grant until after the handshake.
    rsp_ready = 1'b0;
    drive(1'b0, 1, 32'ha86a0c31, 32'h90073fd4, 4'b0010);
    req1_a = 32'h1234_0000; req1_b = 32'h0000_5678; req1_ctrl = 4'b0001; req1_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!rsp_valid && guard < 20);
    check("stall_wait", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_valid%0d", i), rsp_valid, 1);
      check($sformatf("stall_data%0d", i), rsp_data, 32'h38714c05);
      check($sformatf("stall_ready%0d", i), {req0_ready, req1_ready}, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_hs_noready", req1_ready, 0);
    @(negedge clk);
    check("stall_after_ready", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    drain();

    // Illegal control code, then a legal operation.
    drive(1'b0, 1, 32'hffff_0000, 32'h0f0f_0f0f, 4'b0011);
    @(negedge clk);
    @(negedge clk);
    check("illegal_rsp", {rsp_valid, rsp_err, rsp_flags, rsp_data}, {2'b11, 35'd0});
    @(posedge clk); #1;
    drain();
    drive(1'b0, 1, 32'h0000_0005, 32'h0000_0009, 4'b0111);
    drain();

    // Reset during EXEC of a req1 OR discards it; req0 then wins first.
    drive(1'b1, 1, 32'h00f0_0000, 32'h0000_000f, 4'b0001);
    saved = n_rsp;
    rst = 1'b1;
    #1;
    check("midrst_outs", {rsp_valid, ALU_ctrl, A_in}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_norsp", n_rsp, saved);
    rst = 1'b0;
    grant_q.delete();
    fork
      drive(1'b0, 1, 32'h0000_0001, 32'h0000_0001, 4'b0010);
      drive(1'b1, 1, 32'h0000_0003, 32'h0000_0001, 4'b0110);
    join
    drain();
    check("midrst_rsp_count", n_rsp, saved + 2);
    check("midrst_first", (grant_q.size() > 0) ? grant_q[0] : 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
